// File: rtl/grant_index_arbiter.sv
// Three-way round-robin arbiter emitting the winner as a 2-bit encoder-space index.
// A grant holds until done, until the owner withdraws, or until MAX_HOLD cycles pass.
module grant_index_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;
  logic [1:0] winner;

  // Bit 0 of req is outside the rotation and deliberately unused.
  logic unused_req0;
  assign unused_req0 = req[0];

  // Rotating priority starts one past the last owner and wraps 3 -> 1.
  always_comb begin
    winner = 2'd0;
    case (last_q)
      2'd1: begin
        if (req[2])      winner = 2'd2;
        else if (req[3]) winner = 2'd3;
        else if (req[1]) winner = 2'd1;
      end
      2'd2: begin
        if (req[3])      winner = 2'd3;
        else if (req[1]) winner = 2'd1;
        else if (req[2]) winner = 2'd2;
      end
      default: begin
        if (req[1])      winner = 2'd1;
        else if (req[2]) winner = 2'd2;
        else if (req[3]) winner = 2'd3;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (winner != 2'd0) begin
          idx_d   = winner;
          last_d  = winner;
          hold_d  = 8'd0;
          state_d = GRANT;
        end else begin
          idx_d = 2'd0;
        end
      end
      GRANT: begin
        // done has priority over the hold limit, so timeout is only raised when done is low.
        if (done || !req[idx_q]) begin
          idx_d   = 2'd0;
          state_d = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          idx_d     = 2'd0;
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        idx_d   = 2'd0;
        state_d = IDLE;
      end
    endcase
    valid_d = (idx_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      last_q    <= 2'd3;
      hold_q    <= 8'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_grant_index_arbiter.sv
// Scoreboard bench for grant_index_arbiter: two instances (MAX_HOLD 8 and 1) share stimulus
// and are compared each cycle against a per-instance reference model.
module tb_grant_index_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] gi0, gi1;
  logic       gv0, gv1, to0, to1;

  always #5 clk = ~clk;

  grant_index_arbiter #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant_idx(gi0), .grant_valid(gv0), .timeout(to0)
  );

  grant_index_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant_idx(gi1), .grant_valid(gv1), .timeout(to1)
  );

  typedef struct packed {
    logic [1:0] idx;
    logic       valid;
    logic       tmo;
  } exp_t;

  exp_t expQ0[$];
  exp_t expQ1[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model: owner (0 = none), last owner, cycles granted so far, pending timeout pulse.
  int mOwner[2];
  int mLast[2];
  int mHeld[2];
  bit mTmo[2];
  int mMax[2] = '{8, 1};

  function automatic void modelReset();
    for (int i = 0; i < 2; i++) begin
      mOwner[i] = 0;
      mLast[i]  = 3;
      mHeld[i]  = 0;
      mTmo[i]   = 1'b0;
    end
  endfunction

  function automatic void modelStep(int i, logic [3:0] r, logic d);
    if (mOwner[i] == 0) begin
      mTmo[i] = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (mLast[i] + k - 1) % 3 + 1;
        if (r[c] && mOwner[i] == 0) begin
          mOwner[i] = c;
          mLast[i]  = c;
          mHeld[i]  = 1;
        end
      end
    end else if (d || !r[mOwner[i]]) begin
      mOwner[i] = 0;
      mTmo[i]   = 1'b0;
    end else if (mHeld[i] == mMax[i]) begin
      mOwner[i] = 0;
      mTmo[i]   = 1'b1;
    end else begin
      mHeld[i] = mHeld[i] + 1;
    end
  endfunction

  function automatic exp_t modelOut(int i);
    exp_t e;
    e.idx   = 2'(mOwner[i]);
    e.valid = (mOwner[i] != 0);
    e.tmo   = mTmo[i];
    return e;
  endfunction

  task automatic checkOutput(string name, exp_t act, exp_t want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got idx=%0d valid=%0b timeout=%0b, want idx=%0d valid=%0b timeout=%0b",
               name, $time, act.idx, act.valid, act.tmo, want.idx, want.valid, want.tmo);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the sampling edge, queue the expectation.
  task automatic applyStimulus(logic [3:0] r, logic d, logic rs);
    req  = r;
    done = d;
    rst  = rs;
    @(posedge clk);
    if (rs) begin
      modelReset();
    end else begin
      modelStep(0, r, d);
      modelStep(1, r, d);
    end
    expQ0.push_back(modelOut(0));
    expQ1.push_back(modelOut(1));
    #1;
  endtask

  always @(negedge clk) begin
    if (expQ0.size() > 0) checkOutput("dut8", exp_t'({gi0, gv0, to0}), expQ0.pop_front());
    if (expQ1.size() > 0) checkOutput("dut1", exp_t'({gi1, gv1, to1}), expQ1.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] r;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    modelReset();
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b1);

    // All three requesting; done on each grant's second cycle gives rotation 1,2,3,1.
    repeat (14) applyStimulus(4'b1110, (mOwner[0] != 0 && mHeld[0] == 2), 1'b0);
    repeat (2) applyStimulus(4'b0000, 1'b0, 1'b0);

    // Single requester held with no done: hold limit revokes and re-grants.
    repeat (22) applyStimulus(4'b0100, 1'b0, 1'b0);
    repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0);

    // Grant index 3, then withdraw it.
    for (int k = 0; k < 6 && mOwner[0] != 3; k++) applyStimulus(4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0);

    // done asserted from the first grant cycle: done beats the MAX_HOLD=1 limit.
    repeat (6) applyStimulus(4'b0010, 1'b1, 1'b0);
    repeat (2) applyStimulus(4'b0000, 1'b0, 1'b0);

    // Reach grant 2, then assert reset between edges and check outputs clear at once.
    for (int k = 0; k < 12 && mOwner[0] != 2; k++) applyStimulus(4'b0100, 1'b0, 1'b0);
    vectors++;
    if (mOwner[0] != 2) begin
      miscompares++;
      $display("[TB] FAIL reach_grant2: model owner=%0d, want 2", mOwner[0]);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("dut8_async_rst", exp_t'({gi0, gv0, to0}), modelOut(0));
    checkOutput("dut1_async_rst", exp_t'({gi1, gv1, to1}), modelOut(1));
    applyStimulus(4'b1110, 1'b0, 1'b1);
    repeat (4) applyStimulus(4'b1110, 1'b0, 1'b0);

    // Reserved bit 0 alone never grants.
    repeat (20) applyStimulus(4'b0001, 1'b0, 1'b0);

    // Random traffic with requests that change only occasionally so hold limits are reached.
    r = 4'($urandom);
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom);
      applyStimulus(r, ($urandom_range(0, 5) == 0), 1'b0);
    end

    @(negedge clk);
    #1;
    vectors++;
    if (expQ0.size() != 0 || expQ1.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d/%0d pending expectations, want 0/0", expQ0.size(), expQ1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
